uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
UART transmitter with byte FIFO. It sits downstream of the management core's memory-mapped UART register and drives the system-level uart_tx_o pin, which the Verilator DPI UART model samples. It accepts bytes over a valid/ready handshake, buffers them, and serialises them as 8N1 frames, LSB first, at a fixed baud rate derived from parameters.

Parameters:
ClockFrequency, 125_000_000, system clock in Hz
BaudRate, 15_625_000, line rate in bit/s; ClksPerBit = ClockFrequency/BaudRate (8 at defaults)
FifoDepth, 16, FIFO entries, power of two, minimum 2

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
tx_valid_i  input  1  byte offered
tx_data_i  input  8  byte to send
tx_ready_o  output  1  FIFO can accept a byte
tx_o  output  1  serial line, idle high
fifo_level_o  output  $clog2(FifoDepth)+1  entries currently stored
tx_idle_o  output  1  FIFO empty and serialiser in IDLE

Behaviour:
- Reset (async assert, sync release): tx_o=1, tx_ready_o=1, fifo_level_o=0, tx_idle_o=1, FSM=IDLE, counters=0. Reset mid-frame aborts the frame, drops FIFO contents, and drives tx_o high immediately.
- Push: a byte is written when tx_valid_i && tx_ready_o at a rising edge. tx_ready_o = (level != FifoDepth), registered-level based. Push while full is ignored (ready is low).
- Pop: occurs in a cycle when FSM==IDLE and level!=0. The byte is loaded into the shift register, FSM goes to START, and tx_o goes low from the next cycle.
- Push and pop in the same cycle: level unchanged, both take effect. When full, ready is already low, so there is no same-cycle pass-through.
- Empty FIFO with a push at cycle N: level=1 at N+1, pop at N+1, start bit on tx_o from N+2.
- FSM states: IDLE -> START -> DATA -> (PARITY, only with the optional feature) -> STOP -> IDLE.
- Each non-IDLE state holds tx_o for exactly ClksPerBit cycles, timed by a baud counter counting 0..ClksPerBit-1.
- DATA sends bits 0..7, LSB first, using a 3-bit bit index. It leaves DATA after index 7 completes.
- STOP drives 1 for ClksPerBit cycles. On its final cycle, if level!=0, the FSM pops directly and enters START, so there is no extra idle cycle between frames. Otherwise it goes to IDLE.
- Frame length is 10*ClksPerBit cycles (11* with parity). Back-to-back frames are contiguous.
- tx_idle_o = (FSM==IDLE) && (level==0), registered.
- FIFO: circular buffer with wrap-around read/write pointers of $clog2(FifoDepth) bits; the level counter disambiguates full from empty.
- ClksPerBit < 2 is illegal; a simulation-time assertion fires on it.

Optional Feature:
Macro UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for ClksPerBit cycles, and the frame is 11*ClksPerBit.
- When undefined: there is no PARITY state, no parity logic exists, and the frame is 10*ClksPerBit.
- The port list is identical in both cases.

Test Plan:
- Reset check: hold rst_ni low for 5 cycles, then release -> tx_o=1, tx_ready_o=1, fifo_level_o=0, tx_idle_o=1.
- Single byte 0xA5 pushed at cycle 0 (defaults, ClksPerBit=8):
  - tx_o low for cycles 2-9.
  - Data bits 1,0,1,0,0,1,0,1, each 8 cycles.
  - Stop high for cycles 74-81.
  - tx_idle_o=1 from cycle 82.
  - The DPI receiver decodes 0xA5.
- Back-to-back: push 0x01, 0x02, 0x03 in consecutive cycles -> three contiguous 80-cycle frames, no idle gap, bytes received in order.
- Full boundary: hold valid for 20 cycles with the serialiser active ->
  - Exactly FifoDepth+1 bytes accepted (1 popped, 16 stored).
  - fifo_level_o=16 and tx_ready_o=0.
  - Ready rises in the cycle after the next pop.
- Reset mid-frame: assert rst_ni during bit 3 of a frame -> tx_o=1 in the same cycle, level=0, and no further start bit until a new push.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit 1, send 0x03 -> parity bit 0; each frame is 88 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serialiser, LSB first.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (frame grows from 10 to 11 bits).
module uart_tx_fifo #(
  parameter int ClockFrequency = 125_000_000,
  parameter int BaudRate       = 15_625_000,
  parameter int FifoDepth      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         tx_valid_i,
  input  logic [7:0]                   tx_data_i,
  output logic                         tx_ready_o,
  output logic                         tx_o,
  output logic [$clog2(FifoDepth):0]   fifo_level_o,
  output logic                         tx_idle_o
);

  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int CntW       = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam int PtrW       = $clog2(FifoDepth);
  localparam int LvlW       = PtrW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              idle_q;
  logic [7:0]        mem_q [FifoDepth];
  logic              push, pop, bit_done;
  logic [7:0]        head_byte;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Ready depends only on the registered level, so a full FIFO never passes
  // a byte straight through in the same cycle as a pop.
  assign tx_ready_o   = (level_q != LvlW'(FifoDepth));
  assign push         = tx_valid_i && tx_ready_o;
  assign head_byte    = mem_q[rd_ptr_q];
  assign bit_done     = (baud_q == CntW'(ClksPerBit - 1));
  assign fifo_level_o = level_q;
  assign tx_idle_o    = idle_q;

  // FIFO storage: written on an accepted push, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  // Next-state logic for the serialiser; pops happen from IDLE or from the
  // last STOP cycle so consecutive frames abut without an idle gap.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != IDLE) baud_d = bit_done ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (level_q != '0) pop = 1'b1;
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (level_q != '0) pop = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d   = START;
      baud_d    = '0;
      bit_idx_d = '0;
      shift_d   = head_byte;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^head_byte;
`endif
    end
  end

  // Level tracks push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  // Line driver straight from registered state so reset forces idle-high at once.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_o = parity_q;
`endif
      default: tx_o = 1'b1;
    endcase
  end

  // State, counters, pointers and the idle flag (computed from next-state values).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      idle_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      level_q   <= level_d;
      idle_q    <= (state_d == IDLE) && (level_d == '0);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // A bit period shorter than two clocks cannot be timed by the baud counter.
  cpb_legal_a: assert property (@(posedge clk_i) ClksPerBit >= 2);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of reset, single frame, back-to-back
// frames, FIFO full boundary, mid-frame reset and (when built with
// UART_TX_PARITY_EN) the parity bit.
module tb_uart_tx_fifo;
  localparam int CPB = 8;
  localparam int FD  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] data;
  logic       ready, tx, idle;
  logic [4:0] level;

  int checks = 0;
  int fails  = 0;

  uart_tx_fifo dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_valid_i(valid), .tx_data_i(data),
    .tx_ready_o(ready), .tx_o(tx), .fifo_level_o(level), .tx_idle_o(idle)
  );

  always #5 clk = ~clk;

  // Expected line level at offset rel from the start of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int rel);
    int slot;
    if (rel < 0) return 1'b1;
    slot = rel / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (NB == 11 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic test_reset();
    valid = 1'b0; data = 8'h00; rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b want 1", idle); end
    $display("reset: tx=%b ready=%b level=%0d idle=%b", tx, ready, level, idle);
  endtask

  task automatic test_single();
    logic [7:0] rx = 8'h00;
    int rel;
    @(posedge clk); #1;
    for (int k = 0; k < FL + 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      valid = (k == 0); data = 8'hA5;
      @(negedge clk);
      rel = k - 2;
      checks++;
      if (tx !== exp_bit(8'hA5, rel)) begin fails++; $display("FAIL single_tx cycle %0d got %b want %b", k, tx, exp_bit(8'hA5, rel)); end
      if (rel >= CPB && rel < 9 * CPB && (rel % CPB) == CPB / 2) rx[rel / CPB - 1] = tx;
      if (k == 1) begin checks++; if (level !== 5'd1) begin fails++; $display("FAIL single_level1 got %0d want 1", level); end end
      if (k == 2) begin checks++; if (level !== 5'd0) begin fails++; $display("FAIL single_level0 got %0d want 0", level); end end
      if (k == FL + 1) begin checks++; if (idle !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", idle); end end
      if (k == FL + 2) begin checks++; if (idle !== 1'b1) begin fails++; $display("FAIL single_idle got %b want 1", idle); end end
    end
    checks++; if (rx !== 8'hA5) begin fails++; $display("FAIL single_rx got %h want a5", rx); end
    $display("single: received %h", rx);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'h01, 8'h02, 8'h03};
    logic [7:0] rx [3] = '{8'h00, 8'h00, 8'h00};
    int rel, f, r;
    logic e;
    @(posedge clk); #1;
    for (int k = 0; k < 3 * FL + 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      valid = (k < 3); data = bytes[k < 3 ? k : 0];
      @(negedge clk);
      rel = k - 2;
      f = (rel < 0) ? -1 : rel / FL;
      r = (rel < 0) ? rel : rel % FL;
      e = (f >= 0 && f < 3) ? exp_bit(bytes[f], r) : 1'b1;
      checks++;
      if (tx !== e) begin fails++; $display("FAIL b2b_tx cycle %0d got %b want %b", k, tx, e); end
      if (f >= 0 && f < 3 && r >= CPB && r < 9 * CPB && (r % CPB) == CPB / 2) rx[f][r / CPB - 1] = tx;
      if (k == 3 * FL + 1) begin checks++; if (idle !== 1'b0) begin fails++; $display("FAIL b2b_busy got %b want 0", idle); end end
      if (k == 3 * FL + 2) begin checks++; if (idle !== 1'b1) begin fails++; $display("FAIL b2b_idle got %b want 1", idle); end end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx[i] !== bytes[i]) begin fails++; $display("FAIL b2b_rx%0d got %h want %h", i, rx[i], bytes[i]); end
      $display("b2b: frame %0d received %h", i, rx[i]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [2] = '{8'h07, 8'h03};
    logic par [2];
    int rel, f, r;
    logic e;
    @(posedge clk); #1;
    for (int k = 0; k < 2 * FL + 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      valid = (k < 2); data = bytes[k < 2 ? k : 0];
      @(negedge clk);
      rel = k - 2;
      f = (rel < 0) ? -1 : rel / FL;
      r = (rel < 0) ? rel : rel % FL;
      e = (f >= 0 && f < 2) ? exp_bit(bytes[f], r) : 1'b1;
      checks++;
      if (tx !== e) begin fails++; $display("FAIL parity_tx cycle %0d got %b want %b", k, tx, e); end
      if (f >= 0 && f < 2 && r == 9 * CPB + CPB / 2) par[f] = tx;
      if (k == 2 * FL + 2) begin checks++; if (idle !== 1'b1) begin fails++; $display("FAIL parity_idle got %b want 1", idle); end end
    end
    checks++; if (par[0] !== 1'b1) begin fails++; $display("FAIL parity_07 got %b want 1", par[0]); end
    checks++; if (par[1] !== 1'b0) begin fails++; $display("FAIL parity_03 got %b want 0", par[1]); end
    $display("parity: 07 -> %b, 03 -> %b", par[0], par[1]);
  endtask
`endif

  task automatic test_full();
    int acc = 0;
    int waited = 0;
    while (idle !== 1'b1 && waited < 5000) begin @(negedge clk); waited++; end
    checks++; if (idle !== 1'b1) begin fails++; $display("FAIL full_wait_idle got %b want 1", idle); end
    @(posedge clk); #1;
    for (int k = 0; k < CPB * 10 + 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      valid = (k < 20); data = 8'(k);
      @(negedge clk);
      if (valid && ready) acc++;
      if (k == 17) begin
        checks++; if (level !== 5'd16) begin fails++; $display("FAIL full_level got %0d want 16", level); end
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", ready); end
      end
      if (k == CPB * 10 + 1) begin checks++; if (ready !== 1'b0) begin fails++; $display("FAIL full_ready_prepop got %b want 0", ready); end end
      if (k == CPB * 10 + 2) begin
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL full_ready_postpop got %b want 1", ready); end
        checks++; if (level !== 5'd15) begin fails++; $display("FAIL full_level_postpop got %0d want 15", level); end
      end
    end
    checks++; if (acc !== FD + 1) begin fails++; $display("FAIL full_accepted got %0d want %0d", acc, FD + 1); end
    $display("full: accepted %0d bytes", acc);
  endtask

  task automatic test_reset_mid();
    int lows = 0;
    logic [7:0] bytes [3] = '{8'hF0, 8'h11, 8'h22};
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k <= 36; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      valid = (k < 3); data = bytes[k < 3 ? k : 0];
    end
    checks++; if (tx !== 1'b0) begin fails++; $display("FAIL mid_bit3 got %b want 0", tx); end
    checks++; if (level !== 5'd2) begin fails++; $display("FAIL mid_level_before got %0d want 2", level); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_tx_immediate got %b want 1", tx); end
    checks++; if (level !== 5'd0) begin fails++; $display("FAIL mid_level got %0d want 0", level); end
    checks++; if (idle !== 1'b1) begin fails++; $display("FAIL mid_idle got %b want 1", idle); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin fails++; $display("FAIL mid_no_restart got %0d low cycles want 0", lows); end
    $display("reset_mid: low cycles after reset %0d", lows);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
